// File: rtl/pu_mdu_pkg.sv
// Shared widths, op codes and state encoding for the PU iterative multiply/divide unit.
// W = WIDTH+1 data bits, RASB+1 register-address bits.
package pu_mdu_pkg;

    localparam int WIDTH = 7;
    localparam int RASB  = 4;
    localparam int W     = WIDTH + 1;
    localparam int AW    = RASB + 1;
    localparam int CW    = $clog2(W);

    typedef enum logic [1:0] {
        MDU_MUL  = 2'd0,
        MDU_MULH = 2'd1,
        MDU_DIVU = 2'd2,
        MDU_REMU = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } mdu_state_e;

    // Pick the architectural result out of the {hi,lo} register once iteration ends.
    function automatic logic [W-1:0] mdu_sel(input mdu_op_e op, input logic [2*W-1:0] acc);
        logic [W-1:0] r;
        case (op)
            MDU_MUL:  r = acc[W-1:0];
            MDU_MULH: r = acc[2*W-1:W];
            MDU_DIVU: r = acc[W-1:0];
            default:  r = acc[2*W-1:W];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pu_mdu.sv
// Iterative one-bit-per-cycle multiply/divide unit; results leave through a
// registered single-cycle register-file write gated by the datapath's grant.
module pu_mdu
    import pu_mdu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [1:0]    i_op,
    input  logic [AW-1:0] i_dst,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    input  logic          i_flush,
    input  logic          i_wb_gnt,
    output logic          o_busy,
    output logic          o_we,
    output logic [AW-1:0] o_wad,
    output logic [W-1:0]  o_wd
);

    mdu_state_e     r_state, w_state_nxt;
    mdu_op_e        r_op;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_m;
    logic [2*W-1:0] r_acc;
    logic           r_we;
    logic [AW-1:0]  r_wad;
    logic [W-1:0]   r_wd;

    logic           w_accept, w_dz, w_is_div, w_ge;
    logic [W-1:0]   w_hi, w_lo;
    logic [W:0]     w_t, w_opa, w_opb;
    logic [W+1:0]   w_sum;
    logic [2*W-1:0] w_acc_nxt;

    assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
    assign w_dz     = i_op[1] && (i_b == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_dz ? S_WB : S_RUN;
            S_RUN:  if (r_cnt == '0) w_state_nxt = S_WB;
            S_WB:   if (i_wb_gnt) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // One shared (W+1)-bit adder: hi+m for multiply, {rem,q_msb}-divisor for divide.
    assign w_is_div = r_op[1];
    assign w_hi     = r_acc[2*W-1:W];
    assign w_lo     = r_acc[W-1:0];
    assign w_t      = {w_hi, w_lo[W-1]};
    assign w_opa    = w_is_div ? w_t : {1'b0, w_hi};
    assign w_opb    = w_is_div ? ~{1'b0, r_m} : {1'b0, (w_lo[0] ? r_m : {W{1'b0}})};
    assign w_sum    = {1'b0, w_opa} + {1'b0, w_opb} + {{(W+1){1'b0}}, w_is_div};
    assign w_ge     = w_sum[W+1];

    always_comb begin
        w_acc_nxt = {w_sum[W:1], w_sum[0], w_lo[W-1:1]};
        if (w_is_div)
            w_acc_nxt = w_ge ? {w_sum[W-1:0], w_lo[W-2:0], 1'b1}
                             : {w_t[W-1:0],   w_lo[W-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= MDU_MUL;
            r_cnt <= '0;
            r_m   <= '0;
            r_acc <= '0;
            r_we  <= 1'b0;
            r_wad <= '0;
            r_wd  <= '0;
        end else begin
            r_we <= (w_state_nxt == S_WB);
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op  <= mdu_op_e'(i_op);
                    r_wad <= i_dst;
                    r_cnt <= CW'(W - 1);
                    r_m   <= i_op[1] ? i_b : i_a;
                    r_acc <= {{W{1'b0}}, (i_op[1] ? i_a : i_b)};
                    if (w_dz) r_wd <= (i_op[0] ? i_a : {W{1'b1}});
                end
                S_RUN: if (!i_flush) begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) r_wd <= mdu_sel(r_op, w_acc_nxt);
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_we   = r_we;
    assign o_wad  = r_wad;
    assign o_wd   = r_wd;

endmodule

// File: tb/tb_pu_mdu.sv
// Bench for pu_mdu (W=8): directed vector table, grant/flush/reset sequences,
// and randomized operations checked against a plain-arithmetic model.
module tb_pu_mdu;

    logic       clk = 1'b0;
    logic       rst, start, flush, gnt;
    logic [1:0] op;
    logic [4:0] dst;
    logic [7:0] a, b;
    logic       busy, we;
    logic [4:0] wad;
    logic [7:0] wd;

    int n_chk  = 0;
    int n_pass = 0;
    int writes = 0;

    pu_mdu dut (
        .clk(clk), .rst(rst), .i_start(start), .i_op(op), .i_dst(dst),
        .i_a(a), .i_b(b), .i_flush(flush), .i_wb_gnt(gnt),
        .o_busy(busy), .o_we(we), .o_wad(wad), .o_wd(wd)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && we && gnt && !flush) writes <= writes + 1;

    typedef struct {
        logic [1:0] op;
        logic [4:0] dst;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] ref_res(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int unsigned p, xa, ya, r;
        xa = x; ya = y; p = xa * ya;
        case (o)
            2'd0: r = p % 256;
            2'd1: r = p / 256;
            2'd2: r = (ya == 0) ? 255 : xa / ya;
            default: r = (ya == 0) ? xa : xa % ya;
        endcase
        return r[7:0];
    endfunction

    task automatic issue(input logic [1:0] o, input logic [4:0] d, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start = 1'b1; op = o; dst = d; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    // Returns number of edges after the accepting edge until we is seen.
    task automatic wait_we(output int n);
        n = 0;
        while (!we && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [4:0] d,
                          input logic [7:0] x, input logic [7:0] y, input logic [7:0] exp);
        int n, lat, w0;
        lat = (o[1] && y == 8'd0) ? 0 : 8;
        w0 = writes;
        issue(o, d, x, y);
        chk({tag, " busy"}, busy, 1);
        wait_we(n);
        chk({tag, " latency"}, n, lat);
        chk({tag, " wd"}, wd, exp);
        chk({tag, " wad"}, wad, d);
        @(negedge clk);
        chk({tag, " one write"}, writes - w0, 1);
        chk({tag, " idle after"}, {busy, we}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        int n, w0;
        bit ok;
        rst = 1'b1; start = 1'b0; flush = 1'b0; gnt = 1'b1;
        op = 2'd0; dst = '0; a = '0; b = '0;
        #3;
        chk("reset outputs", {busy, we, wad, wd}, '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        tbl[0]  = '{2'd0, 5'd4,  8'd13,  8'd11,  8'd143};
        tbl[1]  = '{2'd1, 5'd5,  8'hFF,  8'h02,  8'h01};
        tbl[2]  = '{2'd0, 5'd6,  8'hFF,  8'h02,  8'hFE};
        tbl[3]  = '{2'd2, 5'd7,  8'd100, 8'd7,   8'd14};
        tbl[4]  = '{2'd3, 5'd8,  8'd100, 8'd7,   8'd2};
        tbl[5]  = '{2'd2, 5'd9,  8'd9,   8'd0,   8'hFF};
        tbl[6]  = '{2'd3, 5'd10, 8'd9,   8'd0,   8'd9};
        tbl[7]  = '{2'd1, 5'd31, 8'hFF,  8'hFF,  8'hFE};
        tbl[8]  = '{2'd2, 5'd1,  8'd255, 8'd1,   8'd255};
        tbl[9]  = '{2'd3, 5'd2,  8'd5,   8'd9,   8'd5};
        tbl[10] = '{2'd0, 5'd0,  8'd0,   8'd77,  8'd0};
        tbl[11] = '{2'd2, 5'd3,  8'd200, 8'd255, 8'd0};
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].dst, tbl[i].a, tbl[i].b, tbl[i].exp);

        // Grant withheld: outputs frozen, start in WB and in completion cycle ignored.
        gnt = 1'b0;
        issue(2'd0, 5'd17, 8'h21, 8'h07);
        wait_we(n);
        chk("hold latency", n, 8);
        w0 = writes;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin start = 1'b1; op = 2'd2; dst = 5'd3; a = 8'd50; b = 8'd5; end
            if (i == 2) start = 1'b0;
            if (!(we === 1'b1 && wd === 8'hE7 && wad === 5'd17)) ok = 1'b0;
        end
        chk("hold stable", ok, 1);
        chk("hold no write", writes - w0, 0);
        start = 1'b1; op = 2'd0; dst = 5'd2; a = 8'd2; b = 8'd2; gnt = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("grant one write", writes - w0, 1);
        chk("start at completion ignored", {busy, we}, 2'b00);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || we !== 1'b0) ok = 1'b0;
        end
        chk("stays idle", ok, 1);
        chk("no extra write", writes - w0, 1);

        // Flush during the third RUN iteration.
        w0 = writes;
        issue(2'd0, 5'd12, 8'd200, 8'd200);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush busy", busy, 0);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (we !== 1'b0) ok = 1'b0;
        end
        chk("flush no we", ok, 1);
        chk("flush no write", writes - w0, 0);

        // Asynchronous reset in the middle of RUN.
        w0 = writes;
        run_op("pre-rst", 2'd0, 5'd21, 8'd9, 8'd9, 8'd81);
        w0 = writes;
        issue(2'd0, 5'd9, 8'd200, 8'd3);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async reset outputs", {busy, we, wad, wd}, '0);
        @(negedge clk);
        rst = 1'b0;
        chk("reset no write", writes - w0, 0);
        run_op("post-rst mul", 2'd0, 5'd11, 8'd3, 8'd5, 8'd15);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] ro;
            logic [7:0] ra, rb;
            logic [4:0] rd;
            ro = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            rd = 5'($urandom);
            run_op($sformatf("rand%0d op%0d %0d,%0d", i, ro, ra, rb), ro, rd, ra, rb, ref_res(ro, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pu_mdu.md
# pu_mdu

Iterative multiply/divide unit for one processing unit (PU). It sits between the PU register file's read ports and its write port. It takes two operands read from the register file plus a destination address, computes one bit per cycle, and returns the result through a single-cycle register-file write. The write goes through a grant handshake shared with the main datapath.

## Interface

Parameters:
- none. Data width W = `WIDTH+1` and register address width `RASB+1` come from pu/pu.vh.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset: rst, asynchronous, active-high; clock clk.
- start  in  1  request an operation; accepted only when busy=0.
- op  in  2  operation, sampled with start: 0 MUL (low W bits), 1 MULH (high W bits, unsigned), 2 DIVU (quotient), 3 REMU (remainder).
- dst  in  `RASB+1`  destination register, sampled with start.
- a  in  W  operand A (multiplicand/dividend), sampled with start.
- b  in  W  operand B (multiplier/divisor), sampled with start.
- flush  in  1  abort the current operation; no write is issued.
- busy  out  1  high whenever the state is not IDLE.
- we  out  1  register-file write enable.
- wad  out  `RASB+1`  write address.
- wd  out  W  write data.
- wb_gnt  in  1  datapath grants the write port this cycle.

## Operation

- States:
  - IDLE: waiting for a request.
  - RUN: iterating, with counter cnt.
  - WB: result held, write pending.
- IDLE → RUN when start=1:
  - latch op, dst, a, b;
  - cnt ← W−1;
  - clear the accumulator.
- IDLE → WB when start=1 with op ∈ {DIVU, REMU} and b=0 (divide-by-zero shortcut):
  - DIVU result is all-ones;
  - REMU result is a.
- RUN, one iteration per cycle:
  - MUL/MULH: unsigned shift-add. Product register {hi,lo} is 2W bits. If lo[0], then hi ← hi+m (W+1-bit add, carry kept). Then shift {carry,hi,lo} right by 1.
  - DIVU/REMU: restoring division. Shift {rem,q} left. If rem ≥ divisor, subtract and set q[0]=1.
  - cnt decrements. When cnt=0, go to WB and load wd with the selected result.
- WB:
  - we=1, wad=dst, wd=result, all held stable.
  - On an edge with wb_gnt=1, the write is done: go to IDLE.
- flush: on any edge in RUN or WB, go to IDLE. we drops on the next cycle. Flush has priority over start and over wb_gnt.
- start while busy=1: ignored, no queueing.
- In the cycle where WB completes, busy is still 1, so a start in that cycle is ignored.
- All results are unsigned and exactly W bits; no overflow flag.
- dst=0 is written normally; register 0 is not special-cased here.

## Timing

- Reset values: busy=0, we=0, wad=0, wd=0; state IDLE; all internal registers 0.
- start accepted at edge k:
  - busy=1 from cycle k+1.
  - we=1 from cycle k+W+1.
  - Write occurs at the first edge ≥ k+W+1 with wb_gnt=1.
  - Minimum start-to-write latency is W+1 edges.
- Divide-by-zero: we=1 from cycle k+1.
- we, wad, wd are registered outputs. They do not change while in WB, whatever wb_gnt does.
- Reset asserted mid-RUN or mid-WB: outputs go to reset values immediately (asynchronous), no write. After rst deasserts, the first start is accepted normally.

## Structure

- pu/pu.vh gets the op-code defines (MDU_MUL, MDU_MULH, MDU_DIVU, MDU_REMU) and a state encoding define set.
- Single module, no sub-modules. The mul and div datapaths share the 2W-bit shift register, the (W+1)-bit adder/subtractor and cnt.
- The counter is sized $clog2(W) bits.

## Test plan

Test plan (W=8 for concrete values):
- MUL a=13, b=11, wb_gnt=1 → we high at cycle k+9, wd=143 (0x8F), wad=dst; busy low afterwards.
- MULH a=0xFF, b=0x02 → wd=0x01; same operands with MUL → wd=0xFE.
- DIVU a=100, b=7 → wd=14; REMU a=100, b=7 → wd=2.
- DIVU a=9, b=0 → we at k+1, wd=0xFF; REMU a=9, b=0 → wd=9.
- wb_gnt held low 5 cycles after WB entry → we, wad, wd constant throughout; exactly one write on grant; a start issued during WB is ignored.
- Abort cases:
  - flush at RUN iteration 3 → we never asserts, busy=0 next cycle.
  - rst pulsed mid-RUN → immediate reset values; a following MUL 3×5 → wd=15.
